// File: rtl/hyperbus_pkg.sv
// Shared HyperBus types: configuration bundle, register word offsets
// and reset defaults used by the register interface and the controller.
package hyperbus_pkg;

    typedef struct packed {
        logic [3:0]  t_latency_access;
        logic        en_latency_additional;
        logic [15:0] t_burst_max;
        logic [3:0]  t_read_write_recovery;
        logic [3:0]  t_rx_clk_delay;
        logic [3:0]  t_tx_clk_delay;
        logic [4:0]  address_mask_msb;
        logic        address_space;
        logic        phys_in_use;
        logic        which_phy;
        logic [3:0]  t_csh_cycles;
    } hyperbus_cfg_t;

    typedef enum logic {StIdle, StResp} regif_state_e;

    // Word indices, i.e. byte offset >> 2
    localparam logic [3:0] RegTLatencyAccess     = 4'h0;
    localparam logic [3:0] RegEnLatencyAdditional = 4'h1;
    localparam logic [3:0] RegTBurstMax          = 4'h2;
    localparam logic [3:0] RegTReadWriteRecovery = 4'h3;
    localparam logic [3:0] RegTRxClkDelay        = 4'h4;
    localparam logic [3:0] RegTTxClkDelay        = 4'h5;
    localparam logic [3:0] RegAddressMaskMsb     = 4'h6;
    localparam logic [3:0] RegAddressSpace       = 4'h7;
    localparam logic [3:0] RegPhysInUse          = 4'h8;
    localparam logic [3:0] RegWhichPhy           = 4'h9;
    localparam logic [3:0] RegTCshCycles         = 4'hA;
    localparam logic [3:0] RegStatus             = 4'hB;

    localparam logic [31:0] RstTLatencyAccess      = 32'd6;
    localparam logic [31:0] RstEnLatencyAdditional = 32'd1;
    localparam logic [31:0] RstTBurstMax           = 32'd350;
    localparam logic [31:0] RstTReadWriteRecovery  = 32'd6;
    localparam logic [31:0] RstTRxClkDelay         = 32'd8;
    localparam logic [31:0] RstTTxClkDelay         = 32'd8;
    localparam logic [31:0] RstAddressMaskMsb      = 32'd25;
    localparam logic [31:0] RstAddressSpace        = 32'd0;
    localparam logic [31:0] RstWhichPhy            = 32'd1;
    localparam logic [31:0] RstTCshCycles          = 32'd1;

    function automatic hyperbus_cfg_t cfg_default(input logic dual_phy);
        hyperbus_cfg_t c;
        c.t_latency_access      = RstTLatencyAccess[3:0];
        c.en_latency_additional = RstEnLatencyAdditional[0];
        c.t_burst_max           = RstTBurstMax[15:0];
        c.t_read_write_recovery = RstTReadWriteRecovery[3:0];
        c.t_rx_clk_delay        = RstTRxClkDelay[3:0];
        c.t_tx_clk_delay        = RstTTxClkDelay[3:0];
        c.address_mask_msb      = RstAddressMaskMsb[4:0];
        c.address_space         = RstAddressSpace[0];
        c.phys_in_use           = dual_phy;
        c.which_phy             = RstWhichPhy[0];
        c.t_csh_cycles          = RstTCshCycles[3:0];
        return c;
    endfunction

endpackage

// File: rtl/hyperbus_cfg_field.sv
// Byte-strobed configuration field register; bits above Width are dropped.
module hyperbus_cfg_field #(
    parameter int unsigned Width = 8,
    parameter logic [31:0] Reset = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wstrb_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q, q_d;
    logic             unused_w;

    always_comb begin
        q_d = q_q;
        for (int i = 0; i < Width; i++) begin
            if (we_i && wstrb_i[2'(i / 8)]) q_d[i] = wdata_i[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) q_q <= Reset[Width-1:0];
        else       q_q <= q_d;
    end

    assign q_o      = q_q;
    assign unused_w = ^{wdata_i, wstrb_i};

endmodule

// File: rtl/hyperbus_cfg_regif.sv
// HyperBus configuration register responder. Define HYPERBUS_CFG_SHADOW_EN
// to defer commits of the shadow into cfg_o until the controller is idle.
module hyperbus_cfg_regif
    import hyperbus_pkg::*;
#(
    parameter int unsigned NumPhys   = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic                 write_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [3:0]           wstrb_i,
    output logic                 ready_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 error_o,
    input  logic                 trans_active_i,
    output hyperbus_cfg_t        cfg_o,
    output logic                 cfg_pending_o
);

    localparam logic [31:0] RstPhysInUse = (NumPhys == 2) ? 32'd1 : 32'd0;

    regif_state_e         state_q;
    logic                 ready_q, error_q;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    hyperbus_cfg_t        shadow;
    logic                 pending;
    logic [3:0]           idx;
    logic                 acc_err, accept, wr_ok;
    logic [15:0]          we;
    logic [DataWidth-1:0] wdata_phy;
    logic                 unused_w;

    assign idx       = addr_i[5:2];
    assign acc_err   = (|addr_i[AddrWidth-1:6]) || (idx > RegStatus) ||
                       (write_i && idx == RegStatus);
    assign accept    = (state_q == StIdle) && valid_i;
    assign wr_ok     = accept && write_i && !acc_err;
    assign we        = wr_ok ? (16'd1 << idx) : 16'd0;
    // A single-PHY controller cannot select or pair a second PHY
    assign wdata_phy = (NumPhys == 2) ? wdata_i : '0;
    assign unused_w  = ^{addr_i[1:0], we[15:11]};

    hyperbus_cfg_field #(.Width(4), .Reset(RstTLatencyAccess)) u_lat (
        .clk_i, .rst_i, .we_i(we[RegTLatencyAccess]), .wdata_i, .wstrb_i,
        .q_o(shadow.t_latency_access));
    hyperbus_cfg_field #(.Width(1), .Reset(RstEnLatencyAdditional)) u_add (
        .clk_i, .rst_i, .we_i(we[RegEnLatencyAdditional]), .wdata_i, .wstrb_i,
        .q_o(shadow.en_latency_additional));
    hyperbus_cfg_field #(.Width(16), .Reset(RstTBurstMax)) u_burst (
        .clk_i, .rst_i, .we_i(we[RegTBurstMax]), .wdata_i, .wstrb_i,
        .q_o(shadow.t_burst_max));
    hyperbus_cfg_field #(.Width(4), .Reset(RstTReadWriteRecovery)) u_rwr (
        .clk_i, .rst_i, .we_i(we[RegTReadWriteRecovery]), .wdata_i, .wstrb_i,
        .q_o(shadow.t_read_write_recovery));
    hyperbus_cfg_field #(.Width(4), .Reset(RstTRxClkDelay)) u_rxd (
        .clk_i, .rst_i, .we_i(we[RegTRxClkDelay]), .wdata_i, .wstrb_i,
        .q_o(shadow.t_rx_clk_delay));
    hyperbus_cfg_field #(.Width(4), .Reset(RstTTxClkDelay)) u_txd (
        .clk_i, .rst_i, .we_i(we[RegTTxClkDelay]), .wdata_i, .wstrb_i,
        .q_o(shadow.t_tx_clk_delay));
    hyperbus_cfg_field #(.Width(5), .Reset(RstAddressMaskMsb)) u_amsb (
        .clk_i, .rst_i, .we_i(we[RegAddressMaskMsb]), .wdata_i, .wstrb_i,
        .q_o(shadow.address_mask_msb));
    hyperbus_cfg_field #(.Width(1), .Reset(RstAddressSpace)) u_aspc (
        .clk_i, .rst_i, .we_i(we[RegAddressSpace]), .wdata_i, .wstrb_i,
        .q_o(shadow.address_space));
    hyperbus_cfg_field #(.Width(1), .Reset(RstPhysInUse)) u_piu (
        .clk_i, .rst_i, .we_i(we[RegPhysInUse]), .wdata_i(wdata_phy), .wstrb_i,
        .q_o(shadow.phys_in_use));
    hyperbus_cfg_field #(.Width(1), .Reset(RstWhichPhy)) u_wphy (
        .clk_i, .rst_i, .we_i(we[RegWhichPhy]), .wdata_i(wdata_phy), .wstrb_i,
        .q_o(shadow.which_phy));
    hyperbus_cfg_field #(.Width(4), .Reset(RstTCshCycles)) u_csh (
        .clk_i, .rst_i, .we_i(we[RegTCshCycles]), .wdata_i, .wstrb_i,
        .q_o(shadow.t_csh_cycles));

    always_comb begin
        rdata_d = '0;
        if (!acc_err && !write_i) begin
            case (idx)
                RegTLatencyAccess:      rdata_d = DataWidth'(shadow.t_latency_access);
                RegEnLatencyAdditional: rdata_d = DataWidth'(shadow.en_latency_additional);
                RegTBurstMax:           rdata_d = DataWidth'(shadow.t_burst_max);
                RegTReadWriteRecovery:  rdata_d = DataWidth'(shadow.t_read_write_recovery);
                RegTRxClkDelay:         rdata_d = DataWidth'(shadow.t_rx_clk_delay);
                RegTTxClkDelay:         rdata_d = DataWidth'(shadow.t_tx_clk_delay);
                RegAddressMaskMsb:      rdata_d = DataWidth'(shadow.address_mask_msb);
                RegAddressSpace:        rdata_d = DataWidth'(shadow.address_space);
                RegPhysInUse:           rdata_d = DataWidth'(shadow.phys_in_use);
                RegWhichPhy:            rdata_d = DataWidth'(shadow.which_phy);
                RegTCshCycles:          rdata_d = DataWidth'(shadow.t_csh_cycles);
                RegStatus:              rdata_d = DataWidth'({pending, trans_active_i});
                default:                rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: if (accept) begin
                    state_q <= StResp;
                    ready_q <= 1'b1;
                    error_q <= acc_err;
                    rdata_q <= rdata_d;
                end
                StResp: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                    rdata_q <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Reset kills an in-flight response in the same cycle it is raised
    assign ready_o = ready_q & ~rst_i;
    assign error_o = error_q & ~rst_i;
    assign rdata_o = rst_i ? '0 : rdata_q;

`ifdef HYPERBUS_CFG_SHADOW_EN
    hyperbus_cfg_t cfg_q;
    logic          pending_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q     <= cfg_default(NumPhys == 2);
            pending_q <= 1'b0;
        end else begin
            if (pending_q && !trans_active_i) begin
                cfg_q     <= shadow;
                pending_q <= 1'b0;
            end
            if (wr_ok && |wstrb_i) pending_q <= 1'b1;
        end
    end

    assign cfg_o   = cfg_q;
    assign pending = pending_q;
`else
    assign cfg_o   = shadow;
    assign pending = 1'b0;
`endif

    assign cfg_pending_o = pending;

endmodule

// File: tb/tb_hyperbus_cfg_regif.sv
// Directed bench for hyperbus_cfg_regif with a register-level reference model.
module tb_hyperbus_cfg_regif;
    import hyperbus_pkg::*;

`ifdef HYPERBUS_CFG_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif
    localparam int          W    [11] = '{4, 1, 16, 4, 4, 4, 5, 1, 1, 1, 4};
    localparam logic [31:0] DFLT [11] = '{6, 1, 350, 6, 8, 8, 25, 0, 1, 1, 1};

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          valid_i = 1'b0, write_i = 1'b0;
    logic [31:0]   addr_i = '0, wdata_i = '0;
    logic [3:0]    wstrb_i = '0;
    logic          ready_o, error_o, trans_active_i = 1'b0, cfg_pending_o;
    logic [31:0]   rdata_o;
    hyperbus_cfg_t cfg_o;

    hyperbus_cfg_regif dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .write_i(write_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .ready_o(ready_o), .rdata_o(rdata_o), .error_o(error_o),
        .trans_active_i(trans_active_i), .cfg_o(cfg_o),
        .cfg_pending_o(cfg_pending_o));

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    bit chk_en = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Reference model: register words, committed words, pending flag
    logic [31:0] sh_m [11];
    logic [31:0] ac_m [11];
    bit          pend_m, resp_m, err_m;
    logic [31:0] rd_m;

    function automatic logic [31:0] apply(logic [31:0] old, logic [31:0] wd,
                                          logic [3:0] s, int w);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r & ((32'd1 << w) - 32'd1);
    endfunction

    function automatic hyperbus_cfg_t model_cfg();
        hyperbus_cfg_t c;
        c.t_latency_access      = ac_m[0][3:0];
        c.en_latency_additional = ac_m[1][0];
        c.t_burst_max           = ac_m[2][15:0];
        c.t_read_write_recovery = ac_m[3][3:0];
        c.t_rx_clk_delay        = ac_m[4][3:0];
        c.t_tx_clk_delay        = ac_m[5][3:0];
        c.address_mask_msb      = ac_m[6][4:0];
        c.address_space         = ac_m[7][0];
        c.phys_in_use           = ac_m[8][0];
        c.which_phy             = ac_m[9][0];
        c.t_csh_cycles          = ac_m[10][3:0];
        return c;
    endfunction

    always @(posedge clk) begin
        logic [31:0] off;
        int          k;
        bit          take;
        if (rst_i) begin
            for (int i = 0; i < 11; i++) begin
                sh_m[i] = DFLT[i];
                ac_m[i] = DFLT[i];
            end
            pend_m = 0; resp_m = 0; err_m = 0; rd_m = 0;
        end else begin
            take = valid_i && !resp_m;
            if (take) begin
                off   = addr_i & 32'h3C;
                k     = int'(off >> 2);
                err_m = (addr_i >> 6) != 0 || off >= 32'h30 ||
                        (write_i && off == 32'h2C);
                rd_m  = 0;
                if (!err_m && !write_i)
                    rd_m = (k == 11) ? {30'b0, pend_m, trans_active_i} : sh_m[k];
            end
            if (SHADOW && pend_m && !trans_active_i) begin
                for (int i = 0; i < 11; i++) ac_m[i] = sh_m[i];
                pend_m = 0;
            end
            if (take && !err_m && write_i) begin
                sh_m[k] = apply(sh_m[k], wdata_i, wstrb_i, W[k]);
                if (!SHADOW) ac_m[k] = sh_m[k];
                else if (wstrb_i != 0) pend_m = 1;
            end
            resp_m = take;
        end
    end

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            chk("ready", ready_o, resp_m && !rst_i);
            if (resp_m && !rst_i) begin
                chk("rdata", rdata_o, rd_m);
                chk("error", error_o, err_m);
            end
            chk("cfg", cfg_o, model_cfg());
            chk("pending", cfg_pending_o, pend_m);
        end
    end

    logic [31:0] last_rdata;
    logic        last_err, last_rdy;

    task automatic req(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        @(negedge clk);
        valid_i = 1; write_i = w; addr_i = a; wdata_i = d; wstrb_i = s;
        @(negedge clk);
        valid_i = 0;
        #1;
        last_rdata = rdata_o; last_err = error_o; last_rdy = ready_o;
    endtask

    task automatic rd(string name, input logic [31:0] a, input logic [31:0] exp);
        req(0, a, 0, 0);
        chk({name, "_rdy"}, last_rdy, 1);
        chk(name, last_rdata, exp);
    endtask

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 0;
        chk_en = 1;
        #1;
        chk("rst_ready", ready_o, 0);
        chk("rst_cfg", cfg_o, cfg_default(1'b1));

        for (int i = 0; i < 11; i++) rd("dflt", 32'(i * 4), DFLT[i]);
        rd("status0", 32'h2C, 32'h0);

        req(1, 32'h04, 32'h0, 4'hF);
        chk("lat_add_pend", cfg_pending_o, SHADOW);
        @(negedge clk); #1;
        chk("lat_add0", cfg_o.en_latency_additional, 0);
        req(1, 32'h04, 32'h1, 4'hF);
        @(negedge clk); #1;
        chk("lat_add1", cfg_o.en_latency_additional, 1);

        @(negedge clk);
        trans_active_i = 1;
        req(1, 32'h08, 32'h100, 4'hF);
        rd("status_busy", 32'h2C, SHADOW ? 32'h3 : 32'h1);
        chk("burst_held", cfg_o.t_burst_max, SHADOW ? 350 : 256);
        @(negedge clk);
        trans_active_i = 0;
        @(negedge clk); #1;
        chk("burst_commit", cfg_o.t_burst_max, 256);
        rd("status_idle", 32'h2C, 32'h0);

        req(1, 32'h08, 32'h15E, 4'hF);
        req(1, 32'h08, 32'hAABB, 4'h2);
        rd("strb_lane1", 32'h08, 32'hAA5E);
        req(1, 32'h00, 32'h5, 4'h0);
        chk("strb0_err", last_err, 0);
        rd("strb0_noop", 32'h00, 32'h6);
        req(1, 32'h00, 32'hFFFF_FFF3, 4'hF);
        rd("trunc", 32'h02, 32'h3);

        rd("err34_data", 32'h34, 32'h0);
        chk("err34", last_err, 1);
        req(1, 32'h2C, 32'hFFFF_FFFF, 4'hF);
        chk("err_wr_status", last_err, 1);
        rd("err_hi", 32'h40, 32'h0);
        chk("err_hi_flag", last_err, 1);

        @(negedge clk);
        valid_i = 1; write_i = 0; addr_i = 32'h08; wstrb_i = 0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            cnt += int'(ready_o);
        end
        valid_i = 0;
        chk("held_valid_rdys", cnt, 2);

        @(negedge clk);
        trans_active_i = 1;
        req(1, 32'h18, 32'h5, 4'hF);
        @(negedge clk);
        trans_active_i = 0;
        valid_i = 1; write_i = 1; addr_i = 32'h1C; wdata_i = 1; wstrb_i = 4'hF;
        @(negedge clk);
        valid_i = 0;
        #1;
        chk("coll_mask", cfg_o.address_mask_msb, 5);
        chk("coll_space", cfg_o.address_space, SHADOW ? 0 : 1);
        chk("coll_pend", cfg_pending_o, SHADOW);
        @(negedge clk); #1;
        chk("coll_space2", cfg_o.address_space, 1);

        @(negedge clk);
        valid_i = 1; write_i = 1; addr_i = 32'h00; wdata_i = 9; wstrb_i = 4'hF;
        @(negedge clk);
        valid_i = 0;
        rst_i = 1;
        #1;
        chk("rst_drop_rdy", ready_o, 0);
        @(negedge clk);
        rst_i = 0;
        rd("rst_restore", 32'h00, 32'h6);
        chk("rst_cfg2", cfg_o, cfg_default(1'b1));

        repeat (2) @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/hyperbus_cfg_regif.md
# hyperbus_cfg_regif

Register-interface responder holding the HyperBus controller's timing and PHY configuration. It answers the register-bus initiator that the system uses to tune the controller, e.g. the 32-bit write of 0x1 to offset 0x4 that enables additional latency. Accepted writes drive the static `cfg_o` bundle consumed by the controller FSM and PHYs. Commits can be deferred until the controller is idle.

## Interface
- `NumPhys`, default 2: PHYs instantiated in the controller (1 or 2).
- `AddrWidth`, default 32: register-bus address width.
- `DataWidth`, default 32: register-bus data width; only 32 is supported.
- `clk_i` in, 1: the only clock.
- `rst_i` in, 1: reset, synchronous, active-high.
- `valid_i` in, 1: request valid; the initiator holds the request until `ready_o`.
- `write_i` in, 1: 1 = write, 0 = read.
- `addr_i` in, AddrWidth: byte address; only bits [5:2] are decoded.
- `wdata_i` in, 32: write data.
- `wstrb_i` in, 4: byte enables.
- `ready_o` out, 1: response strobe, one cycle per request.
- `rdata_o` out, 32: read data, valid with `ready_o`.
- `error_o` out, 1: access error, valid with `ready_o`.
- `trans_active_i` in, 1: controller has a transaction in flight.
- `cfg_o` out, `hyperbus_cfg_t`: active configuration.
- `cfg_pending_o` out, 1: shadow differs from active and is awaiting commit.

## Operation
- Register map, word offsets:
  - 0x00 t_latency_access [3:0], reset 6
  - 0x04 en_latency_additional [0], reset 1
  - 0x08 t_burst_max [15:0], reset 350
  - 0x0C t_read_write_recovery [3:0], reset 6
  - 0x10 t_rx_clk_delay [3:0], reset 8
  - 0x14 t_tx_clk_delay [3:0], reset 8
  - 0x18 address_mask_msb [4:0], reset 25
  - 0x1C address_space [0], reset 0
  - 0x20 phys_in_use [0], reset (NumPhys==2)
  - 0x24 which_phy [0], reset 1
  - 0x28 t_csh_cycles [3:0], reset 1
  - 0x2C STATUS, read-only: {30'b0, cfg_pending, trans_active_i}
- Reads return the shadow value, zero-extended.
- Writes update the shadow per byte lane under `wstrb_i`. Bits above each field's width are discarded.
- `wstrb_i` = 0 is a legal no-op write: no error, no pending.
- When NumPhys==1, writes to phys_in_use and which_phy are forced to 0.
- Error response: offsets 0x30–0x3C, `addr_i` above bit 5 nonzero, or a write to 0x2C. The response is `error_o`=1, `rdata_o`=0, and no state change.
- FSM states:
  - IDLE: `valid_i` moves to RESP and latches the request.
  - RESP: asserts `ready_o` for one cycle, then returns to IDLE.
  - A request still held high after `ready_o` is treated as a new request.

## Timing
- Reset values:
  - `ready_o`=0, `rdata_o`=0, `error_o`=0, `cfg_pending_o`=0.
  - Shadow and `cfg_o` equal the map defaults.
  - FSM in IDLE.
- Response latency: `ready_o` is high exactly 1 cycle after `valid_i` is sampled in IDLE. Throughput is one request per 2 cycles.
- Shadow update happens at the clock edge that enters RESP.
- Commit:
  - Condition: `cfg_pending_o`=1 and `trans_active_i`=0 at an edge.
  - At that edge `cfg_o` takes the shadow and pending clears.
  - `cfg_o` never changes while `trans_active_i`=1.
- Simultaneous commit and shadow write at the same edge: `cfg_o` takes the pre-write shadow, and pending stays 1.
- Reset asserted mid-request drops the response, with no `ready_o`, and restores all defaults.

## Configuration
- `HYPERBUS_CFG_SHADOW_EN` defined: deferred-commit behaviour as above.
- Macro undefined: the shadow is `cfg_o` itself.
  - Writes take effect at the RESP-entry edge regardless of `trans_active_i`.
  - `cfg_pending_o` is tied to 0, and STATUS[1] reads 0.

## Structure
- Shared package `hyperbus_pkg` holds:
  - `hyperbus_cfg_t` (packed struct of the fields above)
  - register offset localparams
  - reset-default localparams
- The same package is used by the controller.
- One sub-module, `hyperbus_cfg_field`: a byte-strobed field register with width and reset parameters, instantiated per register.

## Test plan
- Reset, then read every offset → map defaults returned, `error_o`=0, `ready_o` 1 cycle after `valid_i`.
- Write 0x1 to 0x04 with `wstrb_i`=4'hF while idle → `cfg_o.en_latency_additional`=1 one edge after RESP entry; `cfg_pending_o` pulses 1 cycle (macro defined).
- With `trans_active_i`=1, write 0x08 = 0x100 → `cfg_o.t_burst_max` stays 350 and STATUS reads 0x3. Drop `trans_active_i` → value 0x100 commits next edge and STATUS reads 0x0.
- Write 0x08 = 0xAABB with `wstrb_i`=4'h2 → reads 0xAA5E (350 = 0x015E).
- Read 0x34, and write 0x2C → `error_o`=1, `rdata_o`=0, `cfg_o` unchanged.
- Assert `rst_i` in the RESP cycle after a write to 0x00 → no `ready_o`, and `t_latency_access` reads 6.
